// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry constants, FSM state type and a byte-select
// helper for the direct-mapped data cache (8 lines x 4 bytes, 8-bit address).
package dcache_pkg;

    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int LINES   = 8;
    localparam int BLOCK_W = 32;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int BADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FETCH = 2'd2,
        FILL  = 2'd3
    } state_t;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] get_byte(
        input logic [BLOCK_W-1:0] blk,
        input logic [OFF_W-1:0]   off
    );
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage for the data cache.
// Ports: clk/rst (sync, active-high; clears valid+dirty), idx selects the line
// for the combinational read port and both write ports; byte write
// (byte_en/off/wr_byte, sets dirty) and block fill (fill_en/fill_tag/fill_data,
// sets valid, clears dirty). Fill wins if both are requested.
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               byte_en,
    input  logic [OFF_W-1:0]   off,
    input  logic [7:0]         wr_byte,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data
);

    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [BLOCK_W-1:0] data_d [LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = fill_tag;
            data_d[idx]  = fill_data;
        end else if (byte_en) begin
            dirty_d[idx] = 1'b1;
            data_d[idx][{off, 3'b000} +: 8] = wr_byte;
        end
    end

    // Tag and data need no reset: an invalid line never hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate byte cache between the
// CPU (READ/WRITE/ADDRESS/WRITE_DATA -> READ_DATA/BUSYWAIT) and a 32-bit block
// memory (MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITE_DATA <- MEM_READ_DATA/
// MEM_BUSYWAIT). CLK rising edge; RESET synchronous active-high.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
module dcache
    import dcache_pkg::*;
(
`ifdef DCACHE_STATS_EN
    output logic [15:0]        HIT_COUNT,
    output logic [15:0]        MISS_COUNT,
`endif
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [7:0]         WRITE_DATA,
    output logic [7:0]         READ_DATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [BADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITE_DATA,
    input  logic [BLOCK_W-1:0] MEM_READ_DATA,
    input  logic               MEM_BUSYWAIT
);

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [OFF_W-1:0]   addr_off;

    assign addr_tag = ADDRESS[7:5];
    assign addr_idx = ADDRESS[4:2];
    assign addr_off = ADDRESS[1:0];

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] fill_buf_q, fill_buf_d;

    logic               req;
    logic               hit;
    logic               byte_en;
    logic               fill_en;
    logic               miss_start;
    logic               hit_event;

    assign req = READ | WRITE;
    assign hit = line_valid && (line_tag == addr_tag);

    dcache_array u_array (
        .clk       (CLK),
        .rst       (RESET),
        .idx       (addr_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .byte_en   (byte_en),
        .off       (addr_off),
        .wr_byte   (WRITE_DATA),
        .fill_en   (fill_en),
        .fill_tag  (addr_tag),
        .fill_data (fill_buf_q)
    );

    always_comb begin
        state_d        = state_q;
        fill_buf_d     = fill_buf_q;
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b0;
        MEM_ADDRESS    = '0;
        MEM_WRITE_DATA = '0;
        byte_en        = 1'b0;
        fill_en        = 1'b0;
        miss_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_start = 1'b1;
                    state_d    = line_dirty ? WB : FETCH;
                end else if (WRITE && hit) begin
                    byte_en = 1'b1;
                end
            end
            WB: begin
                MEM_WRITE      = 1'b1;
                MEM_ADDRESS    = {line_tag, addr_idx};
                MEM_WRITE_DATA = line_data;
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (!MEM_BUSYWAIT) begin
                    fill_buf_d = MEM_READ_DATA;
                    state_d    = FILL;
                end
            end
            FILL: begin
                fill_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit_event = (state_q == IDLE) && req && hit;
    assign BUSYWAIT  = req && !((state_q == IDLE) && hit);
    // Gated by hit so stale post-reset data never reaches the CPU.
    assign READ_DATA = hit ? get_byte(line_data, addr_off) : 8'h00;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            fill_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_buf_q <= fill_buf_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_event && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (miss_start && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_event ^ miss_start;
`endif

endmodule
